key_expansion: RTL and testbench

- Iterative AES key schedule (FIPS-197 KeyExpansion) for AES-128/192/256, selected by parameters.
- On a start pulse it loads the cipher key and generates one 32-bit schedule word per clock.
- The whole expanded schedule is presented as one flat register vector.
- It sits ahead of the AES round datapath, which slices round keys from the vector.

---
 rtl/key_expansion.sv | 151 +++++++++++++++
 tb/tb_key_expansion.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion.sv
// Iterative AES key schedule: one 32-bit word per clock into a flat round-key vector.
// Optional macro KEY_EXPANSION_START_ERR_EN adds a start_err pulse for starts ignored while busy.
module key_expansion #(
    parameter int unsigned NK = 4,
    parameter int unsigned NR = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [32*NK-1:0]      key_in,
    output logic [128*(NR+1)-1:0] round_keys,
    output logic                  busy,
    output logic                  done
`ifdef KEY_EXPANSION_START_ERR_EN
    ,
    output logic                  start_err
`endif
);

    localparam int unsigned NW = 4*(NR+1);
    localparam int unsigned IW = $clog2(NW+1);

    generate
        if ((NR != NK+6) || !((NK == 4) || (NK == 6) || (NK == 8))) begin : g_bad_cfg
            $error("key_expansion: illegal NK/NR combination");
        end
    endgenerate

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic {S_IDLE, S_GEN} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q;
    logic [2:0]    mod_q;
    logic [7:0]    rcon_q;
    logic          done_q;
    logic [31:0]   w_q   [NW];
    logic [31:0]   win_q [NK];

    logic          load_en, gen_en, last_gen;
    logic [31:0]   prev_w, sub_in, sub_out, temp_w, new_w;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)    state_d = S_GEN;
            S_GEN:   if (last_gen) state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == S_GEN);
        done     = done_q;
        load_en  = (state_q == S_IDLE) && start;
        gen_en   = (state_q == S_GEN);
        last_gen = gen_en && (idx_q == IW'(NW-1));
    end

    // win_q holds the last NK words: win_q[0] = w[i-NK], win_q[NK-1] = w[i-1],
    // so the schedule never needs a wide read mux on the full array.
    always_comb begin
        prev_w  = win_q[NK-1];
        sub_in  = (mod_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
        sub_out = sub_word(sub_in);
        if (mod_q == 3'd0)
            temp_w = sub_out ^ {rcon_q, 24'h000000};
        else if ((NK > 6) && (mod_q == 3'd4))
            temp_w = sub_out;
        else
            temp_w = prev_w;
        new_w = win_q[0] ^ temp_w;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q  <= '0;
            mod_q  <= '0;
            rcon_q <= '0;
            done_q <= 1'b0;
            for (int unsigned k = 0; k < NW; k++) w_q[k]   <= '0;
            for (int unsigned k = 0; k < NK; k++) win_q[k] <= '0;
        end else begin
            done_q <= last_gen;
            if (load_en) begin
                for (int unsigned k = 0; k < NK; k++) begin
                    w_q[k]   <= key_in[32*(NK-k)-1 -: 32];
                    win_q[k] <= key_in[32*(NK-k)-1 -: 32];
                end
                idx_q  <= IW'(NK);
                mod_q  <= '0;
                rcon_q <= 8'h01;
            end else if (gen_en) begin
                w_q[idx_q] <= new_w;
                for (int unsigned k = 0; k + 1 < NK; k++) win_q[k] <= win_q[k+1];
                win_q[NK-1] <= new_w;
                idx_q <= idx_q + IW'(1);
                mod_q <= (mod_q == 3'(NK-1)) ? 3'd0 : mod_q + 3'd1;
                if (mod_q == 3'd0) rcon_q <= xtime(rcon_q);
            end
        end
    end

    always_comb begin
        round_keys = '0;
        for (int unsigned j = 0; j < NW; j++) round_keys[32*(NW-j)-1 -: 32] = w_q[j];
    end

`ifdef KEY_EXPANSION_START_ERR_EN
    logic start_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) start_err_q <= 1'b0;
        else        start_err_q <= start && (state_q == S_GEN);
    end

    assign start_err = start_err_q;
`endif

endmodule

// File: tb/tb_key_expansion.sv
// Scoreboard bench for key_expansion: AES-128/192/256 instances checked against FIPS-197 words.
`timescale 1ns/1ps
module tb_key_expansion;

    localparam int unsigned W128 = 1408;
    localparam int unsigned W192 = 1664;
    localparam int unsigned W256 = 1920;

    localparam logic [127:0] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEYB   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [191:0] KEY192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    localparam logic [127:0] H128 = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] T128 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    localparam logic [127:0] H192 = 128'h10111213_14151617_5846f2f9_5c43f4fe;
    localparam logic [127:0] T192 = 128'ha4970a33_1a78dc09_c418c271_e3a41d5d;
    localparam logic [127:0] H256 = 128'h10111213_14151617_18191a1b_1c1d1e1f;
    localparam logic [127:0] T256 = 128'h24fc79cc_bf0979e9_371ac23c_6d68de36;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic st128, st192, st256;
    logic [127:0] k128;
    logic [191:0] k192;
    logic [255:0] k256;
    logic [W128-1:0] rk128;
    logic [W192-1:0] rk192;
    logic [W256-1:0] rk256;
    logic busy128, busy192, busy256, done128, done192, done256;
`ifdef KEY_EXPANSION_START_ERR_EN
    logic se128, se192, se256;
`endif

    key_expansion #(.NK(4), .NR(10)) u_aes128 (
        .clk(clk), .rst_n(rst_n), .start(st128), .key_in(k128),
        .round_keys(rk128), .busy(busy128), .done(done128)
`ifdef KEY_EXPANSION_START_ERR_EN
        , .start_err(se128)
`endif
    );

    key_expansion #(.NK(6), .NR(12)) u_aes192 (
        .clk(clk), .rst_n(rst_n), .start(st192), .key_in(k192),
        .round_keys(rk192), .busy(busy192), .done(done192)
`ifdef KEY_EXPANSION_START_ERR_EN
        , .start_err(se192)
`endif
    );

    key_expansion #(.NK(8), .NR(14)) u_aes256 (
        .clk(clk), .rst_n(rst_n), .start(st256), .key_in(k256),
        .round_keys(rk256), .busy(busy256), .done(done256)
`ifdef KEY_EXPANSION_START_ERR_EN
        , .start_err(se256)
`endif
    );

    typedef struct {
        int unsigned  load_cyc;
        logic [127:0] keyhi;
        logic [127:0] head;
        logic [127:0] tail;
    } exp_t;

    exp_t q128[$];
    exp_t q192[$];
    exp_t q256[$];

    int unsigned cyc = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned done_cnt128 = 0;
    int unsigned se_cnt128 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk128(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk_bit(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic chk_run(input string nm, input exp_t e, input int unsigned lat,
                           input logic [127:0] keyhi, input logic [127:0] head,
                           input logic [127:0] tail, input logic bsy);
        chk_int({nm, " latency"}, cyc - e.load_cyc, lat);
        chk128({nm, " w0..3"}, keyhi, e.keyhi);
        chk128({nm, " w4..7"}, head, e.head);
        chk128({nm, " last4"}, tail, e.tail);
        chk_bit({nm, " busy at done"}, bsy, 1'b0);
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s unexpected done at cycle %0d", nm, cyc);
    endtask

    // Monitors: pop expected runs when each DUT signals done.
    logic pd128 = 1'b0, pd192 = 1'b0, pd256 = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (pd128) chk_bit("aes128 done width", done128, 1'b0);
        pd128 = done128;
        if (done128) begin
            done_cnt128++;
            if (q128.size() == 0) unexpected("aes128");
            else begin
                e = q128.pop_front();
                chk_run("aes128", e, 40, rk128[W128-1 -: 128], rk128[W128-129 -: 128],
                        rk128[127:0], busy128);
            end
        end
`ifdef KEY_EXPANSION_START_ERR_EN
        if (se128 === 1'b1) se_cnt128++;
`endif
    end

    always @(negedge clk) begin
        exp_t e;
        if (pd192) chk_bit("aes192 done width", done192, 1'b0);
        pd192 = done192;
        if (done192) begin
            if (q192.size() == 0) unexpected("aes192");
            else begin
                e = q192.pop_front();
                chk_run("aes192", e, 46, rk192[W192-1 -: 128], rk192[W192-129 -: 128],
                        rk192[127:0], busy192);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (pd256) chk_bit("aes256 done width", done256, 1'b0);
        pd256 = done256;
        if (done256) begin
            if (q256.size() == 0) unexpected("aes256");
            else begin
                e = q256.pop_front();
                chk_run("aes256", e, 52, rk256[W256-1 -: 128], rk256[W256-129 -: 128],
                        rk256[127:0], busy256);
            end
        end
    end

    task automatic push128(input int unsigned l);
        q128.push_back('{load_cyc: l, keyhi: KEY128, head: H128, tail: T128});
    endtask

    task automatic wait_cyc(input int unsigned n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic drain(input int unsigned bound);
        int unsigned t = 0;
        while ((q128.size() + q192.size() + q256.size()) != 0 && t < bound) begin
            @(negedge clk);
            #1;
            t++;
        end
        if ((q128.size() + q192.size() + q256.size()) != 0) begin
            checks++;
            errors++;
            $display("FAIL drain timeout: %0d runs still pending",
                     q128.size() + q192.size() + q256.size());
            q128.delete();
            q192.delete();
            q256.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned l;
        int unsigned dc;
        exp_t tmp;

        rst_n = 1'b0;
        st128 = 1'b0; st192 = 1'b0; st256 = 1'b0;
        k128 = '0; k192 = '0; k256 = '0;
        repeat (3) @(negedge clk);
        chk_bit("reset aes128 keys zero", (rk128 != '0), 1'b0);
        chk_bit("reset aes192 keys zero", (rk192 != '0), 1'b0);
        chk_bit("reset aes256 keys zero", (rk256 != '0), 1'b0);
        chk_bit("reset busy128", busy128, 1'b0);
        chk_bit("reset busy192", busy192, 1'b0);
        chk_bit("reset busy256", busy256, 1'b0);
        chk_bit("reset done128", done128, 1'b0);
        chk_bit("reset done192", done192, 1'b0);
        chk_bit("reset done256", done256, 1'b0);
        rst_n = 1'b1;

        // All three key sizes in parallel.
        @(negedge clk);
        k128 = KEY128; k192 = KEY192; k256 = KEY256;
        st128 = 1'b1; st192 = 1'b1; st256 = 1'b1;
        l = cyc + 1;
        push128(l);
        q192.push_back('{load_cyc: l, keyhi: KEY192[191:64], head: H192, tail: T192});
        q256.push_back('{load_cyc: l, keyhi: KEY256[255:128], head: H256, tail: T256});
        @(negedge clk);
        chk_bit("busy128 after load", busy128, 1'b1);
        st128 = 1'b0; st192 = 1'b0; st256 = 1'b0;
        drain(100);

        // Start while busy with a different key is ignored.
        @(negedge clk);
        se_cnt128 = 0;
        k128 = KEY128; st128 = 1'b1;
        l = cyc + 1;
        push128(l);
        @(negedge clk);
        st128 = 1'b0;
        wait_cyc(l + 9);
        k128 = KEYB; st128 = 1'b1;
        @(negedge clk);
        st128 = 1'b0;
        drain(100);
`ifdef KEY_EXPANSION_START_ERR_EN
        chk_int("start_err pulses", se_cnt128, 1);
`endif

        // Reset in the middle of a run aborts it.
        @(negedge clk);
        k128 = KEY128; st128 = 1'b1;
        l = cyc + 1;
        push128(l);
        @(negedge clk);
        st128 = 1'b0;
        wait_cyc(l + 19);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tmp = q128.pop_back();
        chk_bit("abort keys zero", (rk128 != '0), 1'b0);
        chk_bit("abort busy", busy128, 1'b0);
        chk_bit("abort done", done128, 1'b0);
        dc = done_cnt128;
        repeat (60) @(negedge clk);
        chk_int("no done after abort", done_cnt128, dc);

        // Fresh run after the abort.
        k128 = KEY128; st128 = 1'b1;
        l = cyc + 1;
        push128(l);
        @(negedge clk);
        st128 = 1'b0;
        k128 = KEYB;
        drain(100);

        // Start held high: back-to-back runs every 41 cycles; mid-run key changes ignored.
        @(negedge clk);
        k128 = KEY128; st128 = 1'b1;
        l = cyc + 1;
        push128(l);
        push128(l + 41);
        push128(l + 82);
        wait_cyc(l + 19); k128 = KEYB;
        wait_cyc(l + 34); k128 = KEY128;
        wait_cyc(l + 59); k128 = KEYB;
        wait_cyc(l + 74); k128 = KEY128;
        wait_cyc(l + 82); st128 = 1'b0;
        drain(200);
        dc = done_cnt128;
        repeat (50) @(negedge clk);
        chk_int("no run after start drop", done_cnt128, dc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
